jtdd_sdram_sched: RTL

//  Shares the single SDRAM read port among four ROM requesters: main CPU, char, scroll and object.

---
 rtl/jtdd_sdram_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jtdd_sdram_sched.sv
// Four-slot ROM read scheduler for the shared SDRAM port. Each slot has a one-word cache.
// Hits answer combinationally. Misses are arbitrated, with main first or round-robin, and are fetched over req/ack/data_rdy.
module jtdd_sdram_sched #(
    parameter int AW        = 22,
    parameter int MAIN_PRIO = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic [3:0]      slot_cs,
    input  logic [4*AW-1:0] slot_addr,
    output logic [3:0]      slot_ok,
    output logic [127:0]    slot_data,
    output logic            ready,
    output logic            sdram_req,
    input  logic            sdram_ack,
    output logic [AW-1:0]   sdram_addr,
    input  logic            data_rdy,
    input  logic [31:0]     data_read,
    output logic            refresh_en
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t         state_r, state_nx_s;
    logic [AW-1:0]  tag_r [4];
    logic [31:0]    data_r [4];
    logic [3:0]     valid_r;
    logic [1:0]     cur_r, rr_ptr_r, grant_s, rr_nx_s;
    logic [2:0]     cand_s;
    logic           grant_vld_s, fill_s, dl_seen_r;
    logic [3:0]     hit_s, pend_s;
    logic [AW-1:0]  sdram_addr_r;
    logic           sdram_req_r, ready_r, refresh_en_r;

    assign slot_ok    = hit_s;
    assign sdram_req  = sdram_req_r;
    assign sdram_addr = sdram_addr_r;
    assign ready      = ready_r;
    assign refresh_en = refresh_en_r;

    // Cache hit detection and outstanding misses; the slot being fetched is not re-queued
    always_comb begin
        hit_s     = 4'd0;
        pend_s    = 4'd0;
        slot_data = 128'd0;
        for (int i = 0; i < 4; i++) begin
            hit_s[i]  = slot_cs[i] & valid_r[i] & (tag_r[i] == slot_addr[i*AW +: AW]);
            pend_s[i] = slot_cs[i] & ~hit_s[i] & ~((state_r != ST_IDLE) && (cur_r == 2'(i)));
            slot_data[i*32 +: 32] = data_r[i];
        end
    end

    // Arbitration: optional main priority, then round-robin starting at rr_ptr_r
    always_comb begin
        grant_s     = 2'd0;
        grant_vld_s = 1'b0;
        cand_s      = 3'd0;
        if ((MAIN_PRIO != 0) && pend_s[0]) begin
            grant_s     = 2'd0;
            grant_vld_s = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cand_s = {1'b0, rr_ptr_r} + 3'(k);
                if (MAIN_PRIO != 0) begin
                    if (cand_s > 3'd3) cand_s = cand_s - 3'd3;
                    else               cand_s = cand_s;
                end else begin
                    cand_s = {1'b0, cand_s[1:0]};
                end
                if (!grant_vld_s && pend_s[cand_s[1:0]]) begin
                    grant_s     = cand_s[1:0];
                    grant_vld_s = 1'b1;
                end else begin
                    grant_s     = grant_s;
                end
            end
        end
        if (grant_s == 2'd3) rr_nx_s = (MAIN_PRIO != 0) ? 2'd1 : 2'd0;
        else                 rr_nx_s = grant_s + 2'd1;
    end

    // Next-state logic; ack with data in the same cycle completes directly
    always_comb begin
        state_nx_s = state_r;
        fill_s     = 1'b0;
        if (downloading) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) state_nx_s = ST_REQ;
                    else             state_nx_s = ST_IDLE;
                end
                ST_REQ: begin
                    if (sdram_ack && data_rdy) begin
                        fill_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else if (sdram_ack) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        fill_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, request and grant bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= '0;
            cur_r        <= 2'd0;
            rr_ptr_r     <= 2'd1;
        end else begin
            state_r     <= state_nx_s;
            sdram_req_r <= (state_nx_s == ST_REQ);
            if ((state_r == ST_IDLE) && (state_nx_s == ST_REQ)) begin
                sdram_addr_r <= slot_addr[grant_s*AW +: AW];
                cur_r        <= grant_s;
                rr_ptr_r     <= rr_nx_s;
            end
        end
    end

    // Cache fill, using the address that was issued rather than the slot's current address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 32'd0;
            end
        end else if (downloading) begin
            valid_r <= 4'd0;
        end else if (fill_s) begin
            data_r[cur_r]  <= data_read;
            tag_r[cur_r]   <= sdram_addr_r;
            valid_r[cur_r] <= 1'b1;
        end
    end

    // Ready after two idle cycles out of download; refresh allowed only when nothing is queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_seen_r    <= 1'b0;
            ready_r      <= 1'b0;
            refresh_en_r <= 1'b0;
        end else if (downloading) begin
            dl_seen_r    <= 1'b0;
            ready_r      <= 1'b0;
            refresh_en_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                dl_seen_r <= 1'b1;
                if (dl_seen_r) ready_r <= 1'b1;
            end
            refresh_en_r <= ready_r & (state_r == ST_IDLE) & ~|pend_s;
        end
    end

endmodule
